// File: rtl/dm_byte_mem_if.sv
// Request/response bus of the byte-addressable data memory.
interface dm_byte_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_byte_mem.sv
// Byte-addressable word memory with sized loads/stores, error detection,
// a fixed-latency response pipeline and a post-reset clear sequence.
module dm_byte_mem #(
  parameter int unsigned DEPTH  = 3072,
  parameter int unsigned IDX_W  = 12,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  dm_byte_mem_if.slave  bus,
  output logic          busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] clr_idx, clr_idx_nx;
  logic [31:0]      mem [DEPTH];

  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             err;
  logic [31:0]      old_word;
  logic [31:0]      merged;
  logic [31:0]      byte_sh;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;
  logic [31:0]      rsp_word;

  logic             v_pipe [RD_LAT];
  logic [31:0]      d_pipe [RD_LAT];
  logic             e_pipe [RD_LAT];

`ifndef SYNTHESIS
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end
`endif

  // State register and clear counter; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  // Next-state logic: walk every word in CLEAR, then accept requests in RUN.
  always_comb begin
    state_nx      = state;
    clr_idx_nx    = clr_idx;
    busy          = 1'b0;
    bus.req_ready = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (clr_idx == LAST_IDX) begin
          state_nx   = RUN;
          clr_idx_nx = '0;
        end else begin
          clr_idx_nx = clr_idx + 1'b1;
        end
      end
      RUN: bus.req_ready = 1'b1;
      default: state_nx = CLEAR;
    endcase
  end

  // Request decode, alignment/range checks, store merge and load extension.
  always_comb begin
    // a request coinciding with rst is dropped along with the in-flight ones
    accept   = bus.req_valid && bus.req_ready && !rst;
    idx      = bus.req_addr[IDX_W+1:2];
    lane     = bus.req_addr[1:0];
    err      = 1'b0;
    case (bus.req_size)
      2'd1:    if (lane[0]) err = 1'b1;
      2'd2:    if (lane != 2'd0) err = 1'b1;
      2'd3:    err = 1'b1;
      default: ;
    endcase
    if ({{(32-IDX_W){1'b0}}, idx} >= DEPTH) err = 1'b1;
    if ((bus.req_addr >> (IDX_W + 2)) != '0) err = 1'b1;

    old_word = err ? '0 : mem[idx];

    merged = old_word;
    case (bus.req_size)
      2'd0:    merged[{lane, 3'b000} +: 8]        = bus.req_wdata[7:0];
      2'd1:    merged[{lane[1], 4'b0000} +: 16]   = bus.req_wdata[15:0];
      default: merged                             = bus.req_wdata;
    endcase

    byte_sh = old_word >> {lane, 3'b000};
    ld_byte = byte_sh[7:0];
    ld_half = lane[1] ? old_word[31:16] : old_word[15:0];
    case (bus.req_size)
      2'd0:    ld_data = bus.req_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = bus.req_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = old_word;
    endcase

    rsp_word = (accept && !bus.req_we && !err) ? ld_data : '0;
  end

  // Array writes: one zeroed word per clear cycle, or a lane-merged store.
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (accept && bus.req_we && !err) begin
      mem[idx] <= merged;
`ifndef SYNTHESIS
      $display("%d@%h: *%h <= %h", $time, bus.req_pc, {bus.req_addr[31:2], 2'b00}, merged);
`endif
    end
  end

  // Response pipeline, RD_LAT stages; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        v_pipe[i] <= 1'b0;
        d_pipe[i] <= '0;
        e_pipe[i] <= 1'b0;
      end
    end else begin
      v_pipe[0] <= accept;
      d_pipe[0] <= rsp_word;
      e_pipe[0] <= accept && err;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        d_pipe[i] <= d_pipe[i-1];
        e_pipe[i] <= e_pipe[i-1];
      end
    end
  end

  assign bus.rsp_valid = v_pipe[RD_LAT-1];
  assign bus.rsp_rdata = d_pipe[RD_LAT-1];
  assign bus.rsp_err   = e_pipe[RD_LAT-1];

endmodule

// File: tb/tb_dm_byte_mem.sv
// Scoreboard bench for dm_byte_mem: stimulus pushes expected responses with
// their due cycle, a negedge monitor pops and compares.
module tb_dm_byte_mem;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned RD_LAT = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  bit mon_on = 1'b0;
  exp_t q[$];

  dm_byte_mem_if bus();

  dm_byte_mem #(.DEPTH(DEPTH), .IDX_W(IDX_W), .RD_LAT(RD_LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every response must match the oldest expectation and be on time.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check({e.name, "_rdata"}, bus.rsp_rdata, e.rdata);
          check({e.name, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
          check({e.name, "_cycle"}, cyc, e.due);
        end
      end else if (bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0) begin
        check("idle_rsp_zero", {bus.rsp_rdata[31:1], bus.rsp_rdata[0] | bus.rsp_err}, 32'd0);
      end
    end
  end

  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int unsigned guard = 0;
    exp_t e;
    while (!bus.req_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.req_ready) begin
      check({name, "_ready_timeout"}, 32'd0, 32'd1);
    end else begin
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_pc       = 32'h0000_1000 + addr;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.due   = cyc + RD_LAT;
      e.name  = name;
      q.push_back(e);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
    end
  endtask

  // Counts clear cycles after reset release; req_valid may be held meanwhile.
  task automatic wait_clear(input string name);
    int unsigned n = 0;
    bit ready_seen = 1'b0;
    while (busy && n < 100) begin
      if (bus.req_ready) ready_seen = 1'b1;
      n++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    check({name, "_busy_cycles"}, n, DEPTH);
    check({name, "_ready_low"}, {31'd0, ready_seen}, 32'd0);
    check({name, "_ready_after"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check({name, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    wait_clear(name);
  endtask

  initial begin
    int unsigned guard;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    do_reset("reset");

    issue("lw_3c_cleared", 1'b0, 2'd2, 1'b0, 32'h3C, '0, 32'h0, 1'b0);

    issue("sw_8",      1'b1, 2'd2, 1'b0, 32'h8, 32'h1122_3344, 32'h0, 1'b0);
    issue("sb_a",      1'b1, 2'd0, 1'b0, 32'hA, 32'h0000_00AA, 32'h0, 1'b0);
    issue("lw_8_merge", 1'b0, 2'd2, 1'b0, 32'h8, '0, 32'h11AA_3344, 1'b0);

    issue("sw_8b",  1'b1, 2'd2, 1'b0, 32'h8, 32'h8000_F0FF, 32'h0, 1'b0);
    issue("lb_8",   1'b0, 2'd0, 1'b0, 32'h8, '0, 32'hFFFF_FFFF, 1'b0);
    issue("lbu_8",  1'b0, 2'd0, 1'b1, 32'h8, '0, 32'h0000_00FF, 1'b0);
    issue("lh_a",   1'b0, 2'd1, 1'b0, 32'hA, '0, 32'hFFFF_8000, 1'b0);
    issue("lhu_a",  1'b0, 2'd1, 1'b1, 32'hA, '0, 32'h0000_8000, 1'b0);
    issue("lh_8",   1'b0, 2'd1, 1'b0, 32'h8, '0, 32'hFFFF_F0FF, 1'b0);
    issue("lbu_9",  1'b0, 2'd0, 1'b1, 32'h9, '0, 32'h0000_00F0, 1'b0);
    issue("lb_b",   1'b0, 2'd0, 1'b0, 32'hB, '0, 32'hFFFF_FF80, 1'b0);
    issue("lw_8_u", 1'b0, 2'd2, 1'b1, 32'h8, '0, 32'h8000_F0FF, 1'b0);

    issue("err_lh_1",    1'b0, 2'd1, 1'b0, 32'h1, '0, 32'h0, 1'b1);
    issue("err_sw_6",    1'b1, 2'd2, 1'b0, 32'h6, 32'hDEAD_BEEF, 32'h0, 1'b1);
    issue("err_size3",   1'b0, 2'd3, 1'b0, 32'h0, '0, 32'h0, 1'b1);
    issue("err_lw_oor",  1'b0, 2'd2, 1'b0, 4 * DEPTH, '0, 32'h0, 1'b1);
    issue("err_sw_high", 1'b1, 2'd2, 1'b0, 32'h1000_0008, 32'hCAFE_F00D, 32'h0, 1'b1);
    issue("lw_4_intact", 1'b0, 2'd2, 1'b0, 32'h4, '0, 32'h0, 1'b0);
    issue("lw_8_intact", 1'b0, 2'd2, 1'b0, 32'h8, '0, 32'h8000_F0FF, 1'b0);

    issue("sh_e",       1'b1, 2'd1, 1'b0, 32'hE, 32'h1234_BEEF, 32'h0, 1'b0);
    issue("lw_c",       1'b0, 2'd2, 1'b0, 32'hC, '0, 32'hBEEF_0000, 1'b0);
    issue("sb_3f",      1'b1, 2'd0, 1'b0, 32'h3F, 32'h0000_005A, 32'h0, 1'b0);
    issue("lw_3c_last", 1'b0, 2'd2, 1'b0, 32'h3C, '0, 32'h5A00_0000, 1'b0);

    issue("b2b_0", 1'b0, 2'd2, 1'b0, 32'h8,  '0, 32'h8000_F0FF, 1'b0);
    issue("b2b_1", 1'b0, 2'd2, 1'b0, 32'hC,  '0, 32'hBEEF_0000, 1'b0);
    issue("b2b_2", 1'b0, 2'd2, 1'b0, 32'h3C, '0, 32'h5A00_0000, 1'b0);
    issue("b2b_3", 1'b0, 2'd2, 1'b0, 32'h0,  '0, 32'h0, 1'b0);

    issue("sw_20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, 32'h0, 1'b0);
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
    issue("flight_0", 1'b0, 2'd2, 1'b0, 32'h20, '0, 32'h1234_5678, 1'b0);
    issue("flight_1", 1'b0, 2'd2, 1'b0, 32'h8, '0, 32'h8000_F0FF, 1'b0);
    // cycle 2: load presented together with rst; both in-flight loads are dropped
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h20;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    wait_clear("flight_rst");
    issue("lw_20_cleared", 1'b0, 2'd2, 1'b0, 32'h20, '0, 32'h0, 1'b0);
    issue("lw_8_cleared",  1'b0, 2'd2, 1'b0, 32'h8,  '0, 32'h0, 1'b0);

    issue("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hA5A5_5A5A, 32'h0, 1'b0);
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    do_reset("midclear");
    issue("lw_10_cleared", 1'b0, 2'd2, 1'b0, 32'h10, '0, 32'h0, 1'b0);

    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("queue_drained", q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
